// File: rtl/pipe_pkg.sv
// Shared pipeline constants: Tnew/Tuse encoding, MDU latencies, exception vector,
// and the busy-timer state type.
package pipe_pkg;

  localparam int unsigned T_W = 2;
  localparam logic [T_W-1:0] TUSE_UNUSED = 2'd3;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned MD_CNT_W     = 4;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {StIdle, StBusy} md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the operation latency on a start and counts
// down to zero; busy while the count is nonzero.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYC);
  localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYC);

  md_state_e state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start && !cancel) begin
      // A start while busy reloads; a cancelled start leaves the count alone.
      cnt_d   = is_div ? DivLoad : MultLoad;
      state_d = (cnt_d != '0) ? StBusy : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
        end
        StBusy: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: data, MDU and eret
// stalls, plus the exception flush request that overrides them.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     D_rs,
  input  logic [4:0]     D_rt,
  input  logic [T_W-1:0] D_Tuse_rs,
  input  logic [T_W-1:0] D_Tuse_rt,
  input  logic [4:0]     E_A3,
  input  logic [4:0]     M_A3,
  input  logic           E_RegWrite,
  input  logic           M_RegWrite,
  input  logic [T_W-1:0] E_Tnew,
  input  logic [T_W-1:0] M_Tnew,
  input  logic           D_isMD,
  input  logic           E_mdStart,
  input  logic           E_mdIsDiv,
  input  logic           D_eret,
  input  logic           E_mtc0EPC,
  input  logic           M_mtc0EPC,
  input  logic           M_ExcReq,
  output logic           F_en,
  output logic           D_en,
  output logic           E_clr,
  output logic           Req,
  output logic           md_busy
);

  logic rs_used, rt_used;
  logic stall_rs, stall_rt, stall_md, stall_eret, stall;

  // An unused source (Tuse 3) can never be outrun by any Tnew; made explicit here.
  assign rs_used = (D_Tuse_rs != TUSE_UNUSED);
  assign rt_used = (D_Tuse_rt != TUSE_UNUSED);

  assign stall_rs = rs_used && (D_rs != 5'd0) &&
                    ((E_RegWrite && (E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                     (M_RegWrite && (M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));

  assign stall_rt = rt_used && (D_rt != 5'd0) &&
                    ((E_RegWrite && (E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                     (M_RegWrite && (M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));

  assign stall_md   = D_isMD && (E_mdStart || md_busy);
  assign stall_eret = D_eret && (E_mtc0EPC || M_mtc0EPC);
  assign stall      = stall_rs || stall_rt || stall_md || stall_eret;

  assign Req = M_ExcReq && !reset;

  always_comb begin
    F_en  = 1'b1;
    D_en  = 1'b1;
    E_clr = 1'b0;
    if (!Req) begin
      F_en  = !stall;
      E_clr = stall;
    end
  end

  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (E_mdStart),
    .is_div (E_mdIsDiv),
    .cancel (Req),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-count model.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic E_RegWrite, M_RegWrite, D_isMD, E_mdStart, E_mdIsDiv;
  logic D_eret, E_mtc0EPC, M_mtc0EPC, M_ExcReq;
  logic F_en, D_en, E_clr, Req, md_busy;

  int checks = 0;
  int passed = 0;
  // Model: edges seen so far, and the first edge index at which the MDU is free.
  int cycle = 0;
  int busy_end = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYC (MULT_N),
    .DIV_CYC  (DIV_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_RegWrite (E_RegWrite),
    .M_RegWrite (M_RegWrite),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .D_isMD     (D_isMD),
    .E_mdStart  (E_mdStart),
    .E_mdIsDiv  (E_mdIsDiv),
    .D_eret     (D_eret),
    .E_mtc0EPC  (E_mtc0EPC),
    .M_mtc0EPC  (M_mtc0EPC),
    .M_ExcReq   (M_ExcReq),
    .F_en       (F_en),
    .D_en       (D_en),
    .E_clr      (E_clr),
    .Req        (Req),
    .md_busy    (md_busy)
  );

  function automatic logic m_busy();
    return cycle < busy_end;
  endfunction

  function automatic logic m_src_hazard(input logic [4:0] r, input logic [1:0] tuse);
    int tu;
    tu = tuse;
    if (r == 0) return 1'b0;
    if (E_RegWrite && E_A3 == r && int'(E_Tnew) > tu) return 1'b1;
    if (M_RegWrite && M_A3 == r && int'(M_Tnew) > tu) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return m_src_hazard(D_rs, D_Tuse_rs) || m_src_hazard(D_rt, D_Tuse_rt) ||
           (D_isMD && (E_mdStart || m_busy())) || (D_eret && (E_mtc0EPC || M_mtc0EPC));
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    reset = 0; D_rs = 0; D_rt = 0; E_A3 = 0; M_A3 = 0;
    D_Tuse_rs = 3; D_Tuse_rt = 3; E_Tnew = 0; M_Tnew = 0;
    E_RegWrite = 0; M_RegWrite = 0; D_isMD = 0; E_mdStart = 0; E_mdIsDiv = 0;
    D_eret = 0; E_mtc0EPC = 0; M_mtc0EPC = 0; M_ExcReq = 0;
  endtask

  // Check all outputs against the model for the current inputs.
  task automatic settle(input string tag);
    logic req_e, st;
    #2;
    req_e = M_ExcReq && !reset;
    st = m_stall();
    chk({tag, ".Req"}, Req, req_e);
    chk({tag, ".F_en"}, F_en, req_e ? 1'b1 : !st);
    chk({tag, ".D_en"}, D_en, 1'b1);
    chk({tag, ".E_clr"}, E_clr, req_e ? 1'b0 : st);
    chk({tag, ".md_busy"}, md_busy, m_busy());
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    if (reset) busy_end = 0;
    else if (E_mdStart && !M_ExcReq) busy_end = cycle + (E_mdIsDiv ? DIV_N : MULT_N);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    settle("reset");
    chk("reset_F_en", F_en, 1'b1);
    chk("reset_busy", md_busy, 1'b0);
    tick();
    reset = 0;

    // lw in E feeding addu rs in D
    E_RegWrite = 1; E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 1;
    settle("lw_e");
    chk("lw_e_stall_F", F_en, 1'b0);
    chk("lw_e_stall_clr", E_clr, 1'b1);
    tick();
    E_RegWrite = 0; E_A3 = 0; E_Tnew = 0; M_RegWrite = 1; M_A3 = 8; M_Tnew = 1;
    settle("lw_m");
    chk("lw_m_nostall", F_en, 1'b1);
    tick();

    // $0 destination never stalls
    idle_inputs();
    E_RegWrite = 1; E_A3 = 0; E_Tnew = 2; D_rs = 0; D_Tuse_rs = 0;
    settle("zero_reg");
    chk("zero_reg_nostall", F_en, 1'b1);
    tick();

    // divide then multiply, MD instruction held in D
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? DIV_N : MULT_N;
      idle_inputs();
      D_isMD = 1; E_mdStart = 1; E_mdIsDiv = (k == 0);
      settle("md_start");
      chk("md_start_stall", F_en, 1'b0);
      tick();
      E_mdStart = 0;
      for (int i = 0; i <= n; i++) begin
        settle("md_run");
        chk("md_busy_len", md_busy, i < n);
        chk("md_stall_len", F_en, !(i < n));
        tick();
      end
    end

    // exception beats data stall and cancels an MDU start
    idle_inputs();
    E_RegWrite = 1; E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 1;
    E_mdStart = 1; E_mdIsDiv = 1; M_ExcReq = 1;
    settle("req");
    chk("req_Req", Req, 1'b1);
    chk("req_F_en", F_en, 1'b1);
    chk("req_E_clr", E_clr, 1'b0);
    tick();
    idle_inputs();
    settle("req_after");
    chk("req_no_start", md_busy, 1'b0);
    tick();

    // exception while a divide is in flight does not disturb the count
    E_mdStart = 1; E_mdIsDiv = 1;
    settle("div2_start");
    tick();
    E_mdStart = 0;
    for (int i = 0; i < 4; i++) begin
      settle("div2_run");
      tick();
    end
    for (int i = 0; i <= 6; i++) begin
      M_ExcReq = (i == 0);
      settle("div2_req");
      chk("div2_req_busy", md_busy, i < 6);
      tick();
    end
    idle_inputs();

    // eret behind mtc0 EPC in E, then M, then released
    D_eret = 1; E_mtc0EPC = 1;
    settle("eret_e");
    chk("eret_e_stall", F_en, 1'b0);
    tick();
    E_mtc0EPC = 0; M_mtc0EPC = 1;
    settle("eret_m");
    chk("eret_m_stall", F_en, 1'b0);
    tick();
    M_mtc0EPC = 0;
    settle("eret_go");
    chk("eret_release", F_en, 1'b1);
    tick();

    // reset mid-divide
    idle_inputs();
    E_mdStart = 1; E_mdIsDiv = 1;
    settle("rst_start");
    tick();
    E_mdStart = 0;
    for (int i = 0; i < 3; i++) begin
      settle("rst_run");
      tick();
    end
    reset = 1;
    settle("rst_assert");
    chk("rst_assert_busy", md_busy, 1'b1);
    tick();
    reset = 0;
    settle("rst_after");
    chk("rst_after_busy", md_busy, 1'b0);
    chk("rst_after_F_en", F_en, 1'b1);
    chk("rst_after_E_clr", E_clr, 1'b0);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      D_rs       = 5'($urandom_range(0, 3));
      D_rt       = 5'($urandom_range(0, 3));
      E_A3       = 5'($urandom_range(0, 3));
      M_A3       = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      E_Tnew     = 2'($urandom_range(0, 3));
      M_Tnew     = 2'($urandom_range(0, 3));
      E_RegWrite = 1'($urandom_range(0, 1));
      M_RegWrite = 1'($urandom_range(0, 1));
      D_isMD     = 1'($urandom_range(0, 1));
      E_mdStart  = ($urandom_range(0, 5) == 0);
      E_mdIsDiv  = 1'($urandom_range(0, 1));
      D_eret     = ($urandom_range(0, 3) == 0);
      E_mtc0EPC  = ($urandom_range(0, 3) == 0);
      M_mtc0EPC  = ($urandom_range(0, 3) == 0);
      M_ExcReq   = ($urandom_range(0, 7) == 0);
      settle("rand");
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it decides whether the F/D stage registers hold, whether a bubble is inserted into the D/E register, and whether the exception request `Req` is broadcast to every stage register. It owns the multiply/divide busy timer, so MD-class instructions in D stall while the MDU is occupied.

## Interface
Parameters:
- `MULT_CYC`, default 5: busy cycles after a mult/multu start.
- `DIV_CYC`, default 10: busy cycles after a div/divu start.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `D_rs`, `D_rt` in 5: source registers of the instruction in D.
- `D_Tuse_rs`, `D_Tuse_rt` in 2: cycles until the D instruction needs rs/rt. 3 means unused.
- `E_A3`, `M_A3` in 5: destination register in E/M.
- `E_RegWrite`, `M_RegWrite` in 1: the E/M instruction writes the GPR file.
- `E_Tnew`, `M_Tnew` in 2: cycles until the E/M result is forwardable.
- `D_isMD` in 1: D holds mult/div/mthi/mtlo/mfhi/mflo.
- `E_mdStart` in 1: E issues a mult/div this cycle.
- `E_mdIsDiv` in 1: the E start is a divide.
- `D_eret` in 1: D holds eret.
- `E_mtc0EPC`, `M_mtc0EPC` in 1: E/M holds mtc0 to EPC.
- `M_ExcReq` in 1: CP0 exception/interrupt request for the M instruction.
- `F_en` out 1: PC and F/D register load enable.
- `D_en` out 1: D/E register load enable.
- `E_clr` out 1: D/E register loads a bubble.
- `Req` out 1: flush all stage registers and redirect to 0x4180.
- `md_busy` out 1: MDU timer nonzero.

## Operation
- Data-hazard stall. `stall_rs` is asserted when all of the following hold:
  - `D_rs != 0`.
  - For E: `E_RegWrite && E_A3 == D_rs && E_Tnew > D_Tuse_rs`, or the same test on M (`M_RegWrite && M_A3 == D_rs && M_Tnew > D_Tuse_rs`).
- `stall_rt` uses the same rule on `D_rt` / `D_Tuse_rt`.
- MD stall: `D_isMD && (E_mdStart || md_busy)`.
- eret stall: `D_eret && (E_mtc0EPC || M_mtc0EPC)`.
- `stall` is the OR of all four.
- Output rules, with `Req` having top priority:
  - `Req = M_ExcReq && !reset`.
  - When `Req=1`: `F_en=1`, `D_en=1`, `E_clr=0`. The stage registers self-clear on `Req`.
  - Otherwise `F_en = !stall`, `D_en = 1`, `E_clr = stall`.
- Busy timer `cnt` is 4 bits and unsigned:
  - On a clock edge with `E_mdStart && !Req`, load `DIV_CYC` if `E_mdIsDiv`, else `MULT_CYC`.
  - Otherwise, if `cnt != 0`, decrement.
  - `md_busy = (cnt != 0)`.
- The timer has two states: IDLE (`cnt=0`) and BUSY (`cnt>0`).
  - BUSY→IDLE when the count reaches 0.
  - A start while BUSY reloads the count. D stalling prevents this in normal flow, but the reload is the defined behaviour.
- Boundary cases:
  - `Req` with `E_mdStart` on the same edge: the start is ignored and `cnt` is unchanged.
  - `Req` while BUSY: the count continues. An already-started operation completes.
  - `D_rs == 0`: never a hazard, regardless of Tnew.
  - Tnew equal to Tuse: no stall (forwarding covers it).

## Timing
- Reset values: `cnt=0`, `md_busy=0`, `Req=0`, `F_en=1`, `D_en=1`, `E_clr=0`.
- Reset asserted mid-operation clears `cnt` on that edge.
- `F_en`, `D_en`, `E_clr`, `Req` are combinational from the current inputs and `cnt`. Zero-cycle latency.
- `md_busy` goes high the cycle after the start edge:
  - Mult started at edge t: `md_busy=1` for exactly `MULT_CYC` cycles, low in the cycle starting at edge t+`MULT_CYC`.
  - Div: same pattern for `DIV_CYC` cycles.
- The MD stall also covers the start cycle itself, via `E_mdStart`.

## Structure
- Shared package `pipe_pkg`:
  - Tnew/Tuse width (2) and the "unused" Tuse encoding (3).
  - `MULT_CYC` and `DIV_CYC` defaults.
  - Exception vector 0x4180.
- One sub-module, `md_busy_timer`: holds `cnt` and has ports `clk`, `reset`, `start`, `is_div`, `cancel`, `busy`.
- Hazard comparison logic stays inline in `pipe_hazard_ctrl`.

## Test plan
- E: lw $8 (`E_Tnew=2`, `E_RegWrite=1`, `E_A3=8`). D: addu using $8 as rs (`D_Tuse_rs=1`).
  - Required: `F_en=0`, `E_clr=1`.
  - Next cycle with M: `M_Tnew=1`: no stall.
- Write to $0 in E with `E_Tnew=2`, `D_rs=0`, `D_Tuse_rs=0` -> no stall.
- `E_mdStart=1`, `E_mdIsDiv=1` at edge t, then `D_isMD=1` held.
  - Required: stall in the start cycle and for 10 following cycles.
  - `md_busy` drops at edge t+10.
  - Repeat as mult: drop at t+5.
- `M_ExcReq=1` while a data stall condition is present and `E_mdStart=1`.
  - Required: `Req=1`, `F_en=1`, `E_clr=0`, `cnt` stays 0.
- Div running (`cnt=6`) when `M_ExcReq` pulses -> `cnt` keeps decrementing to 0.
- `D_eret` with `E_mtc0EPC=1` -> stall, then one cycle later with `M_mtc0EPC=1` -> stall, then release.
- Reset asserted while `cnt=7` -> next cycle `cnt=0`, all outputs at reset values.
